serial_link_phy_ctrl: RTL and testbench

SERIAL_LINK_PHY_CTRL -- requirements
Module: serial_link_phy_ctrl

---
 rtl/serial_link_pkg.sv | 15 +
 rtl/serial_link_phy_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_link_phy_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared types for the serial link PHY controller: TX beat type and the
// controller state encoding.
package serial_link_pkg;

  typedef logic [15:0] phy_data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LINK  = 3'd1,
    RAW   = 3'd2,
    DRAIN = 3'd3,
    APPLY = 3'd4
  } phy_ctrl_state_e;

endpackage

// File: rtl/serial_link_phy_ctrl.sv
// PHY TX front-end: muxes data-link or raw test-pattern beats onto the PHY and
// applies clock-divider/shift config only after the line has been idle.
module serial_link_phy_ctrl #(
  parameter type         phy_data_t      = serial_link_pkg::phy_data_t,
  parameter int unsigned MaxClkDiv       = 32,
  parameter int unsigned IdleCycles      = 2,
  parameter int unsigned ResetClkDiv     = 8,
  parameter int unsigned ResetShiftStart = 2,
  parameter int unsigned ResetShiftEnd   = 6
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [$clog2(MaxClkDiv):0]       cfg_clk_div_i,
  input  logic [$clog2(MaxClkDiv):0]       cfg_shift_start_i,
  input  logic [$clog2(MaxClkDiv):0]       cfg_shift_end_i,
  input  logic                             cfg_update_i,
  output logic                             cfg_busy_o,
  output logic                             cfg_error_o,
  output logic [$clog2(MaxClkDiv):0]       clk_div_o,
  output logic [$clog2(MaxClkDiv):0]       clk_shift_start_o,
  output logic [$clog2(MaxClkDiv):0]       clk_shift_end_o,
  input  logic                             raw_en_i,
  input  phy_data_t                        link_data_i,
  input  logic                             link_valid_i,
  output logic                             link_ready_o,
  input  phy_data_t                        raw_data_i,
  input  logic                             raw_valid_i,
  output logic                             raw_ready_o,
  output phy_data_t                        phy_data_o,
  output logic                             phy_valid_o,
  input  logic                             phy_ready_i,
  output serial_link_pkg::phy_ctrl_state_e dbg_state_o
);
  import serial_link_pkg::*;

  localparam int unsigned CW   = $clog2(MaxClkDiv) + 1;
  localparam int unsigned CntW = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(IdleCycles);

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // once valid is raised it stays high with stable data until that cycle.

  phy_ctrl_state_e r_state;
  logic            r_pending;
  logic            r_err;
  logic [CntW-1:0] r_cnt;
  logic [CW-1:0]   r_sh_div, r_sh_start, r_sh_end;
  logic [CW-1:0]   r_div, r_start, r_end;

  logic w_raw_mode;
  logic w_sel_valid;
  logic w_switch;
  logic w_cfg_ok;
  logic w_cnt_done;

  assign w_raw_mode  = (r_state == RAW);
  assign w_sel_valid = w_raw_mode ? raw_valid_i : link_valid_i;
  assign w_switch    = r_pending || (raw_en_i != w_raw_mode);
  assign w_cfg_ok    = (cfg_clk_div_i != '0) &&
                       (cfg_shift_start_i < cfg_clk_div_i) &&
                       (cfg_shift_end_i < cfg_clk_div_i);
  assign w_cnt_done  = ((32'(r_cnt) + 32'd1) >= IdleCycles);

  always_comb begin
    phy_data_o   = link_data_i;
    phy_valid_o  = 1'b0;
    link_ready_o = 1'b0;
    raw_ready_o  = 1'b0;
    case (r_state)
      LINK: begin
        phy_data_o   = link_data_i;
        phy_valid_o  = link_valid_i;
        link_ready_o = phy_ready_i;
      end
      RAW: begin
        phy_data_o  = raw_data_i;
        phy_valid_o = raw_valid_i;
        raw_ready_o = phy_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_sh_div   <= CW'(ResetClkDiv);
      r_sh_start <= CW'(ResetShiftStart);
      r_sh_end   <= CW'(ResetShiftEnd);
      r_div      <= CW'(ResetClkDiv);
      r_start    <= CW'(ResetShiftStart);
      r_end      <= CW'(ResetShiftEnd);
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: r_state <= raw_en_i ? RAW : LINK;
        LINK, RAW: begin
          // Leave only on a cycle where no beat is left hanging on the PHY.
          if (w_switch && (!w_sel_valid || phy_ready_i)) begin
            r_state <= DRAIN;
            r_cnt   <= '0;
          end
        end
        DRAIN: begin
          if (w_cnt_done) r_state <= r_pending ? APPLY : IDLE;
          if (r_cnt != CntMax) r_cnt <= r_cnt + CntW'(1);
        end
        APPLY: begin
          r_div     <= r_sh_div;
          r_start   <= r_sh_start;
          r_end     <= r_sh_end;
          r_pending <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A request landing in APPLY re-arms pending for the next drain.
      if (cfg_update_i) begin
        if (w_cfg_ok) begin
          r_sh_div   <= cfg_clk_div_i;
          r_sh_start <= cfg_shift_start_i;
          r_sh_end   <= cfg_shift_end_i;
          r_pending  <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign cfg_busy_o        = r_pending;
  assign cfg_error_o       = r_err;
  assign clk_div_o         = r_div;
  assign clk_shift_start_o = r_start;
  assign clk_shift_end_o   = r_end;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_serial_link_phy_ctrl.sv
// Directed bench for serial_link_phy_ctrl: beat ordering through a scoreboard
// queue, config apply/reject timing, mode switching and mid-drain reset.
module tb_serial_link_phy_ctrl;
  import serial_link_pkg::*;

  localparam int W  = 16;
  localparam int CW = 6;

  logic            clk;
  logic            rst_n;
  logic [CW-1:0]   cfg_clk_div, cfg_shift_start, cfg_shift_end;
  logic            cfg_update;
  logic            cfg_busy, cfg_error;
  logic [CW-1:0]   clk_div, clk_shift_start, clk_shift_end;
  logic            raw_en;
  phy_data_t       link_data, raw_data, phy_data;
  logic            link_valid, link_ready, raw_valid, raw_ready;
  logic            phy_valid, phy_ready;
  phy_ctrl_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  bit  last_hs  = 0;
  bit  raw_phase = 0;

  serial_link_phy_ctrl dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .cfg_clk_div_i     (cfg_clk_div),
    .cfg_shift_start_i (cfg_shift_start),
    .cfg_shift_end_i   (cfg_shift_end),
    .cfg_update_i      (cfg_update),
    .cfg_busy_o        (cfg_busy),
    .cfg_error_o       (cfg_error),
    .clk_div_o         (clk_div),
    .clk_shift_start_o (clk_shift_start),
    .clk_shift_end_o   (clk_shift_end),
    .raw_en_i          (raw_en),
    .link_data_i       (link_data),
    .link_valid_i      (link_valid),
    .link_ready_o      (link_ready),
    .raw_data_i        (raw_data),
    .raw_valid_i       (raw_valid),
    .raw_ready_o       (raw_ready),
    .phy_data_o        (phy_data),
    .phy_valid_o       (phy_valid),
    .phy_ready_i       (phy_ready),
    .dbg_state_o       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples two time units before the rising edge, then returns just after it.
  task automatic tick();
    logic [W-1:0] exp;
    @(negedge clk);
    #3;
    last_hs = phy_valid && phy_ready;
    if (last_hs) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("beat_data", 32'(phy_data), 32'(exp));
      end
    end
    if (raw_phase) check("link_ready_in_raw", 32'(link_ready), 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input bit is_raw, input phy_data_t d, input bit rnd_ready);
    bit done;
    done = 0;
    if (is_raw) begin raw_data = d; raw_valid = 1'b1; end
    else begin link_data = d; link_valid = 1'b1; end
    exp_q.push_back(d);
    for (int i = 0; i < 40 && !done; i++) begin
      phy_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ((cyc % 8) == 7);
      tick();
      done = last_hs;
    end
    check("beat_timeout", 32'(done), 1);
    if (is_raw) raw_valid = 1'b0;
    else link_valid = 1'b0;
    phy_ready = 1'b0;
  endtask

  task automatic wait_state(input phy_ctrl_state_e target, input int budget);
    bit hit;
    hit = (dbg_state == target);
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = (dbg_state == target);
    end
    check("wait_state_timeout", 32'(hit), 1);
  endtask

  task automatic request_cfg(input logic [CW-1:0] dv, input logic [CW-1:0] ss, input logic [CW-1:0] se);
    cfg_clk_div = dv; cfg_shift_start = ss; cfg_shift_end = se;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input int dv, input int ss, input int se);
    check({tag, "_div"},   32'(clk_div),         dv);
    check({tag, "_start"}, 32'(clk_shift_start), ss);
    check({tag, "_end"},   32'(clk_shift_end),   se);
  endtask

  logic [CW-1:0] bad_tbl [3][3];

  initial begin
    bad_tbl[0] = '{6'd0, 6'd0, 6'd0};
    bad_tbl[1] = '{6'd4, 6'd4, 6'd3};
    bad_tbl[2] = '{6'd4, 6'd0, 6'd4};

    rst_n = 1'b0; cfg_clk_div = '0; cfg_shift_start = '0; cfg_shift_end = '0;
    cfg_update = 1'b0; raw_en = 1'b0; link_data = '0; link_valid = 1'b0;
    raw_data = '0; raw_valid = 1'b0; phy_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_phy_valid", 32'(phy_valid), 0);
    check("rst_link_ready", 32'(link_ready), 0);
    check("rst_raw_ready", 32'(raw_ready), 0);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_error", 32'(cfg_error), 0);
    check_cfg("rst_cfg", 8, 2, 6);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    check("idle_to_link", 32'(dbg_state), 32'(LINK));

    // Link beats with the PHY ready only every 8th cycle
    for (int k = 0; k < 4; k++) send_beat(1'b0, phy_data_t'($urandom_range(0, 16'hFFFF)), 1'b0);
    check_cfg("link_cfg", 8, 2, 6);

    // Update 4/1/3 while a beat is stalled on the PHY
    link_data = 16'hA001; link_valid = 1'b1; phy_ready = 1'b0;
    exp_q.push_back(16'hA001);
    tick();
    request_cfg(6'd4, 6'd1, 6'd3);
    #1;
    check("upd_busy", 32'(cfg_busy), 1);
    check("upd_hold_link", 32'(dbg_state), 32'(LINK));
    check("upd_beat_held", 32'(phy_valid), 1);
    phy_ready = 1'b1;
    tick();
    link_data = 16'hA002;
    exp_q.push_back(16'hA002);
    #1;
    check("drain1_state", 32'(dbg_state), 32'(DRAIN));
    check("drain1_valid", 32'(phy_valid), 0);
    check("drain1_ready", 32'(link_ready), 0);
    check("drain1_busy", 32'(cfg_busy), 1);
    tick();
    #1;
    check("drain2_state", 32'(dbg_state), 32'(DRAIN));
    check("drain2_valid", 32'(phy_valid), 0);
    tick();
    #1;
    check("apply_state", 32'(dbg_state), 32'(APPLY));
    check("apply_valid", 32'(phy_valid), 0);
    check("apply_busy", 32'(cfg_busy), 1);
    check_cfg("apply_old_cfg", 8, 2, 6);
    tick();
    #1;
    check("post_apply_idle", 32'(dbg_state), 32'(IDLE));
    check("post_apply_busy", 32'(cfg_busy), 0);
    check_cfg("applied_cfg", 4, 1, 3);
    tick();
    #1;
    check("relink_valid", 32'(phy_valid), 1);
    tick();
    check("relink_hs", 32'(last_hs), 1);
    link_valid = 1'b0; phy_ready = 1'b0;

    // Rejected updates, including each boundary that fails
    for (int k = 0; k < 3; k++) begin
      request_cfg(bad_tbl[k][0], bad_tbl[k][1], bad_tbl[k][2]);
      #1;
      check("rej_error", 32'(cfg_error), 1);
      check("rej_busy", 32'(cfg_busy), 0);
      tick();
      #1;
      check("rej_error_clear", 32'(cfg_error), 0);
      check_cfg("rej_cfg", 4, 1, 3);
    end
    check("rej_stay_link", 32'(dbg_state), 32'(LINK));

    // Largest accepted shifts for div 4
    request_cfg(6'd4, 6'd3, 6'd3);
    #1;
    check("edge_busy", 32'(cfg_busy), 1);
    check("edge_error", 32'(cfg_error), 0);
    wait_state(IDLE, 10);
    check_cfg("edge_cfg", 4, 3, 3);

    // Second update during drain overwrites the first
    tick();
    request_cfg(6'd4, 6'd1, 6'd3);
    tick();
    #1;
    check("dbl_drain", 32'(dbg_state), 32'(DRAIN));
    request_cfg(6'd16, 6'd4, 6'd12);
    wait_state(IDLE, 10);
    check_cfg("dbl_cfg", 16, 4, 12);
    check("dbl_busy", 32'(cfg_busy), 0);

    // raw_en rises while a link beat is outstanding
    tick();
    link_data = 16'hB003; link_valid = 1'b1; phy_ready = 1'b0;
    exp_q.push_back(16'hB003);
    tick();
    raw_en = 1'b1; raw_data = 16'hC000; raw_valid = 1'b1;
    exp_q.push_back(16'hC000);
    #1;
    check("sw_hold_link", 32'(dbg_state), 32'(LINK));
    check("sw_raw_ready", 32'(raw_ready), 0);
    check("sw_phy_data", 32'(phy_data), 32'h0000B003);
    tick();
    phy_ready = 1'b1;
    tick();
    link_data = 16'hDEAD;
    raw_phase = 1;
    #1;
    check("sw_drain1", 32'(dbg_state), 32'(DRAIN));
    check("sw_drain1_valid", 32'(phy_valid), 0);
    tick();
    #1;
    check("sw_drain2_valid", 32'(phy_valid), 0);
    tick();
    #1;
    check("sw_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    #1;
    check("sw_raw", 32'(dbg_state), 32'(RAW));
    check("sw_raw_ready1", 32'(raw_ready), 1);
    tick();
    check("sw_raw_hs", 32'(last_hs), 1);
    for (int k = 1; k < 4; k++) send_beat(1'b1, phy_data_t'(16'hC000 + k), 1'b1);

    // Reset in the middle of a drain with an update pending
    request_cfg(6'd4, 6'd1, 6'd3);
    #1;
    check("rd_busy", 32'(cfg_busy), 1);
    tick();
    #1;
    check("rd_drain", 32'(dbg_state), 32'(DRAIN));
    raw_phase = 0;
    rst_n = 1'b0; raw_en = 1'b0; link_valid = 1'b0;
    #1;
    check("rd_state", 32'(dbg_state), 32'(IDLE));
    check("rd_phy_valid", 32'(phy_valid), 0);
    check("rd_link_ready", 32'(link_ready), 0);
    check("rd_raw_ready", 32'(raw_ready), 0);
    check("rd_busy_clr", 32'(cfg_busy), 0);
    check("rd_error", 32'(cfg_error), 0);
    check_cfg("rd_cfg", 8, 2, 6);
    tick();
    rst_n = 1'b1;
    #1;
    check("rd_rel_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    #1;
    check("rd_rel_link", 32'(dbg_state), 32'(LINK));
    check("q_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
